// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a held valid/ack output, framing-error and overrun pulses.
module uart_rx #(
  parameter int BAUDRATE = 56600,
  parameter int HZ       = 200_000_000,
  parameter int DIVIDER  = HZ / BAUDRATE,
  parameter int HALF     = DIVIDER / 2
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_serial,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ack,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic        tick;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sr_q, sr_d, data_q, data_d;
  logic        valid_q, valid_d, busy_q, busy_d, ferr_q, ferr_d, ovr_q, ovr_d;
  assign rx_s = sync_q[1];
  // The start bit is sampled half a bit in; every later sample is a full bit apart.
  assign tick = cnt_q == ((state_q == START) ? 32'(HALF - 1) : 32'(DIVIDER - 1));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    idx_d   = idx_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = valid_q & ~i_ack;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (tick) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d = '0;
        sr_d  = {rx_s, sr_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (tick) begin
        cnt_d = '0;
        if (!rx_s) begin
          ferr_d  = 1'b1;
          state_d = BRK;
        end else begin
          state_d = IDLE;
          // A same-cycle ack frees the holding slot, so the new byte is kept.
          if (valid_q && !i_ack) ovr_d = 1'b1;
          else begin
            data_d  = sr_q;
            valid_d = 1'b1;
          end
        end
      end
      BRK: if (rx_s) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_serial};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
endmodule
